pri_arb_n: RTL and testbench

Parametrised, registered N-input priority encoder/arbiter, the next generation of the team's combinational 4-input priority encoder. Request pulses are captured into a sticky pending register. The highest-priority pending index is presented on a valid/ready output port and cleared only when accepted. It sits between interrupt/event sources and a single consumer (controller or sequencer) that services one index at a time.

---
 rtl/pri_arb_n.sv | 134 +++++++++++++
 tb/tb_pri_arb_n.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pri_arb_n.sv
// pri_arb_n: registered N-input priority arbiter; sticky pending bits, one grant at a time on valid/ready.
// Define PRI_RR_EN for round-robin priority; otherwise the highest pending index always wins.
module pri_arb_n #(
  parameter  int N  = 8,
  parameter  int CW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [IW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] merge_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  pending_reg, pending_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic          accept;
  logic [N-1:0]  clr;
  logic [N-1:0]  sel_vec;
  logic          sel_any;
  logic [IW-1:0] sel_idx;
  logic          merge_hit;

  assign accept = (state_reg == HOLD) && out_ready;

  // One-hot clear of the index being handed to the consumer this edge.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_clr
      assign clr[gi] = accept && (idx_reg == IW'(gi));
    end
  endgenerate

  // Only registered pending is selectable; a fresh req waits one edge.
  assign sel_vec      = pending_reg & ~clr;
  assign sel_any      = |sel_vec;
  assign pending_next = sel_vec | req;
  assign merge_hit    = |(req & sel_vec);

  always_comb begin
    cnt_next = cnt_reg;
    if (merge_hit && (cnt_reg != {CW{1'b1}})) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

`ifdef PRI_RR_EN
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] cand;

  // Search descends from ptr-1, wrapping; the nearest candidate is visited last so it wins.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr_reg) + N - k) % N);
      if (sel_vec[cand]) begin
        sel_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (accept) begin
      ptr_reg <= idx_reg;
    end
  end
`else
  // Ascending scan, so the highest set index is the last one written.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_vec[i]) begin
        sel_idx = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          state_next = HOLD;
          idx_next   = sel_idx;
        end
      end
      HOLD: begin
        if (accept) begin
          if (sel_any) begin
            idx_next = sel_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign out_valid = (state_reg == HOLD);
  assign out_idx   = idx_reg;
  assign pending   = pending_reg;
  assign merge_cnt = cnt_reg;

endmodule

// File: tb/tb_pri_arb_n.sv
// Self-checking bench for pri_arb_n: behavioural model compared every cycle plus directed literal checks.
module tb_pri_arb_n;

`ifdef PRI_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;
  logic [2:0] out_idx;
  logic       out_valid;
  logic [7:0] pending;
  logic [7:0] merge_cnt;

  logic [3:0] req4 = 4'h0;
  logic       ready4 = 1'b0;
  logic [1:0] idx4;
  logic       valid4;
  logic [3:0] pend4;
  logic [7:0] cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pri_arb_n #(.N(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .pending(pending), .merge_cnt(merge_cnt)
  );

  pri_arb_n #(.N(4), .CW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .out_idx(idx4), .out_valid(valid4),
    .out_ready(ready4), .pending(pend4), .merge_cnt(cnt4)
  );

  // Behavioural model: pending set, current grant, merge count, rotate pointer.
  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_idx;
  logic [2:0] m_ptr;
  logic [7:0] m_cnt;
  logic       m_acc;
  logic [7:0] m_sel;

  function automatic int pick(input logic [7:0] v, input int ptr);
    int base;
    int c;
    base = RR ? ptr : 0;
    for (int k = 1; k <= 8; k++) begin
      c = (base + 8 - k) % 8;
      if (((v >> c) & 8'd1) != 8'd0) return c;
    end
    return 0;
  endfunction

  assign m_acc = m_valid && out_ready;
  assign m_sel = m_acc ? (m_pend & ~(8'd1 << m_idx)) : m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 8'h00;
      m_valid <= 1'b0;
      m_idx   <= 3'd0;
      m_ptr   <= 3'd0;
      m_cnt   <= 8'd0;
    end else begin
      m_pend <= m_sel | req;
      if ((req & m_sel) != 8'h00 && m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
      if (m_acc) m_ptr <= m_idx;
      if (!m_valid || m_acc) begin
        if (m_sel != 8'h00) begin
          m_valid <= 1'b1;
          m_idx   <= 3'(pick(m_sel, int'(m_ptr)));
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("model_valid", int'(out_valid), int'(m_valid));
    chk("model_idx", int'(out_idx), int'(m_idx));
    chk("model_pending", int'(pending), int'(m_pend));
    chk("model_merge_cnt", int'(merge_cnt), int'(m_cnt));
  endtask

  // Inputs change on the falling edge; outputs are checked there too, after the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 8'h00; out_ready = 1'b0; req4 = 4'h0; ready4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] pats4 [4];
  int         exp4 [4];
  int         rr_seq [8];

  initial begin
    pats4 = '{4'b1010, 4'b0110, 4'b0011, 4'b0001};
    exp4  = '{3, 2, 1, 0};
    rr_seq = '{6, 5, 4, 3, 2, 1, 0, 7};

    #1 rst_n = 1'b0;
    #1;
    chk("por_valid", int'(out_valid), 0);
    chk("por_pending", int'(pending), 0);
    chk("por_cnt", int'(merge_cnt), 0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    // Fixed order 5,2,1 from a single pulse, first grant two edges after it.
    req = 8'b0010_0110; out_ready = 1'b1;
    tick();
    req = 8'h00;
    chk("fp_pend", int'(pending), 8'h26);
    chk("fp_v0", int'(out_valid), 0);
    tick(); chk("fp_g5", int'(out_idx), 5); chk("fp_v5", int'(out_valid), 1);
    tick(); chk("fp_g2", int'(out_idx), 2);
    tick(); chk("fp_g1", int'(out_idx), 1);
    tick(); chk("fp_idle", int'(out_valid), 0);

    // Backpressure holds index 7.
    do_reset();
    req = 8'h81;
    tick();
    req = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_idx7", int'(out_idx), 7);
      chk("bp_v", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick(); chk("bp_idx0", int'(out_idx), 0); chk("bp_v0", int'(out_valid), 1);
    tick(); chk("bp_idle", int'(out_valid), 0);

    // Set wins over clear while req[3] is held.
    do_reset();
    req = 8'h08; out_ready = 1'b1;
    tick(); chk("sw_cnt0", int'(merge_cnt), 0);
    tick(); chk("sw_g3", int'(out_idx), 3); chk("sw_cnt1", int'(merge_cnt), 1);
    tick(); chk("sw_pend", int'(pending), 8'h08); chk("sw_gap", int'(out_valid), 0);
    tick(); chk("sw_regrant", int'(out_idx), 3); chk("sw_rv", int'(out_valid), 1);
    chk("sw_cnt2", int'(merge_cnt), 2);
    req = 8'h00;

    // Merge counting and saturation.
    do_reset();
    req = 8'h08;
    tick(); tick(); tick(); tick();
    req = 8'h00;
    tick(); chk("mg_cnt3", int'(merge_cnt), 3);
    req = 8'h08;
    for (int i = 0; i < 260; i++) tick();
    chk("mg_sat", int'(merge_cnt), 255);
    req = 8'h00; out_ready = 1'b1;
    tick(); tick(); tick();

    // Async reset in the middle of a held grant.
    do_reset();
    req = 8'hA5;
    tick(); tick();
    req = 8'h00;
    chk("ar_v", int'(out_valid), 1); chk("ar_idx", int'(out_idx), 7);
    chk("ar_pend", int'(pending), 8'hA5); chk("ar_cnt", int'(merge_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_v0", int'(out_valid), 0);
    chk("ar_pend0", int'(pending), 0);
    chk("ar_cnt0", int'(merge_cnt), 0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;

`ifdef PRI_RR_EN
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    tick(); tick(); chk("rr_g7", int'(out_idx), 7);
    for (int i = 0; i < 8; i++) begin
      tick(); chk("rr_rot", int'(out_idx), rr_seq[i]);
    end
    do_reset();
    req = 8'h88; out_ready = 1'b1;
    tick(); tick(); chk("rr_a7", int'(out_idx), 7);
    tick(); chk("rr_a3", int'(out_idx), 3);
    tick(); chk("rr_b7", int'(out_idx), 7);
    tick(); chk("rr_b3", int'(out_idx), 3);
    req = 8'h00;
`endif

    // Four-input regression against the old encoder's priority.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      req4 = pats4[i];
      tick();
      req4 = 4'h0;
      tick();
      chk("n4_valid", int'(valid4), 1);
      chk("n4_idx", int'(idx4), exp4[i]);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n4_none", int'(valid4), 0);
    end

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) req = 8'($urandom) & 8'($urandom);
      else req = 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    req = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
